// File: rtl/decode_operand_select.sv
// decode_operand_select
//   Registered N-way operand select for the Decode stage. Each accepted beat
//   captures one WIDTH-bit lane of in_bus chosen by in_sel. A select with no
//   lane behind it is flagged on out_err, carries zero data, and is counted
//   in a saturating error counter.
//   A main register drives out_*. A skid register absorbs one extra beat, so
//   in_ready can be registered and has no combinational path from out_ready.
//
//   Optional feature macro: DECODE_SEL_PARITY_EN
//     When it is defined, the block adds per-lane even parity input in_par
//     and output out_par_err. A parity mismatch on the selected lane is also
//     counted in err_cnt, once per beat.
//
//   state | meaning
//   EMPTY | no beat buffered, out_valid=0
//   ONE   | main register holds a beat, skid empty
//   TWO   | main and skid both hold beats, in_ready=0

module decode_operand_select #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 18,
    parameter int SEL_W  = 6,
    parameter int ERR_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ERR_W-1:0]        err_cnt
`ifdef DECODE_SEL_PARITY_EN
    ,
    input  logic [NUM_IN-1:0]       in_par,
    output logic                    out_par_err
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // One bit wider than in_sel so that NUM_IN = 2**SEL_W is still representable.
    localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_IN);
    localparam logic [ERR_W-1:0] CNT_MAX  = '1;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [ERR_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic [SEL_W-1:0]   main_sel_q,  main_sel_d;
    logic               main_err_q,  main_err_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [SEL_W-1:0]   skid_sel_q,  skid_sel_d;
    logic               skid_err_q,  skid_err_d;

    logic [WIDTH-1:0]   lane_sel;
    logic               beat_err;
    logic [WIDTH-1:0]   beat_data;
    logic               beat_bad;
    logic               accept;
    logic               pop;

`ifdef DECODE_SEL_PARITY_EN
    logic               par_bit;
    logic               beat_par_err;
    logic               main_par_q, main_par_d;
    logic               skid_par_q, skid_par_d;
`endif

    // Lane mux: explicit compare per lane, so an out-of-range select never
    // aliases onto a real lane and never indexes past the bus.
    always_comb begin
        lane_sel = '0;
`ifdef DECODE_SEL_PARITY_EN
        par_bit  = 1'b0;
`endif
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                lane_sel = in_bus[k*WIDTH +: WIDTH];
`ifdef DECODE_SEL_PARITY_EN
                par_bit  = in_par[k];
`endif
            end
        end
    end

    // Beat formation: range flag, forced-zero data and the count qualifier.
    always_comb begin
        beat_err  = ({1'b0, in_sel} >= NUM_IN_W);
        beat_data = beat_err ? '0 : lane_sel;
`ifdef DECODE_SEL_PARITY_EN
        beat_par_err = !beat_err && ((^lane_sel) != par_bit);
        beat_bad     = beat_err || beat_par_err;
`else
        beat_bad     = beat_err;
`endif
    end

    // Flush wins over both handshakes; a beat offered during flush is dropped.
    assign accept = in_valid && in_ready_q && !flush;
    assign pop    = (state_q != EMPTY) && out_ready && !flush;

    // Buffer FSM: next state and main/skid register contents.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;
`ifdef DECODE_SEL_PARITY_EN
        main_par_d  = main_par_q;
        skid_par_d  = skid_par_q;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_data_d = beat_data;
                        main_sel_d  = in_sel;
                        main_err_d  = beat_err;
`ifdef DECODE_SEL_PARITY_EN
                        main_par_d  = beat_par_err;
`endif
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid_data_d = beat_data;
                        skid_sel_d  = in_sel;
                        skid_err_d  = beat_err;
`ifdef DECODE_SEL_PARITY_EN
                        skid_par_d  = beat_par_err;
`endif
                        state_d     = TWO;
                    end else if (accept && pop) begin
                        main_data_d = beat_data;
                        main_sel_d  = in_sel;
                        main_err_d  = beat_err;
`ifdef DECODE_SEL_PARITY_EN
                        main_par_d  = beat_par_err;
`endif
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_data_d = skid_data_q;
                        main_sel_d  = skid_sel_q;
                        main_err_d  = skid_err_q;
`ifdef DECODE_SEL_PARITY_EN
                        main_par_d  = skid_par_q;
`endif
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is precomputed from the next state so it leaves a flop.
    always_comb begin
        in_ready_d = (state_d != TWO);
    end

    // Saturating error counter; flush does not clear it.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && beat_bad && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, handshake and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    // Beat storage registers; cleared on reset so outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
`ifdef DECODE_SEL_PARITY_EN
            main_par_q  <= 1'b0;
            skid_par_q  <= 1'b0;
`endif
        end else begin
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
`ifdef DECODE_SEL_PARITY_EN
            main_par_q  <= main_par_d;
            skid_par_q  <= skid_par_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;
    assign out_err   = main_err_q;
    assign err_cnt   = cnt_q;
`ifdef DECODE_SEL_PARITY_EN
    assign out_par_err = main_par_q;
`endif

endmodule
